// File: rtl/ex_iter_pkg.sv
// Shared execute-stage definitions: opcode classes/ops, bus types, constants
// and the iterative-unit FSM encoding.
package ex_iter_pkg;

    localparam int WORD_WIDTH = 32;

    typedef logic [7:0]            ex_op_bus_t;
    typedef logic [WORD_WIDTH-1:0] word_bus_t;
    typedef logic [4:0]            reg_addr_bus_t;

    localparam logic [2:0] EX_HIGH_SPECIAL = 3'd0;
    localparam logic [2:0] EX_HIGH_LOGIC   = 3'd1;

    localparam logic [4:0] EX_LOGIC_AND        = 5'd0;
    localparam logic [4:0] EX_LOGIC_OR         = 5'd1;
    localparam logic [4:0] EX_LOGIC_XOR        = 5'd2;
    localparam logic [4:0] EX_LOGIC_NOR        = 5'd3;
    localparam logic [4:0] EX_LOGIC_SHLEFT     = 5'd4;
    localparam logic [4:0] EX_LOGIC_SHRIGHTLOG = 5'd5;
    localparam logic [4:0] EX_LOGIC_SHRIGHTARI = 5'd6;
    localparam logic [4:0] EX_LOGIC_LUI        = 5'd7;
    localparam logic [4:0] EX_SPECIAL_NOP      = 5'd0;

    localparam word_bus_t     ZERO_WORD = 32'h0000_0000;
    localparam reg_addr_bus_t REG_ZERO  = 5'd0;
    localparam logic          ENABLE    = 1'b1;
    localparam logic          DISABLE   = 1'b0;

    typedef enum logic [1:0] {
        SH_LEFT      = 2'd0,
        SH_RIGHT_LOG = 2'd1,
        SH_RIGHT_ARI = 2'd2,
        SH_NONE      = 2'd3
    } shift_op_t;

    typedef enum logic {
        EXI_IDLE  = 1'b0,
        EXI_SHIFT = 1'b1
    } exi_state_t;

    // Maps a LOGIC-class op code onto the shifter's direction/kind select.
    function automatic shift_op_t to_shift_op(input logic [4:0] op);
        shift_op_t res;
        case (op)
            EX_LOGIC_SHLEFT:     res = SH_LEFT;
            EX_LOGIC_SHRIGHTLOG: res = SH_RIGHT_LOG;
            EX_LOGIC_SHRIGHTARI: res = SH_RIGHT_ARI;
            default:             res = SH_NONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ex_iter_unit_shift_step.sv
// One iteration of the shifter: moves acc by k bits in the selected direction.
module ex_shift_step
    import ex_iter_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] acc,
    input  logic [4:0]            k,
    input  shift_op_t             op,
    output logic [WORD_WIDTH-1:0] shifted
);

    // Select the shift kind; arithmetic right replicates acc's top bit.
    always_comb begin
        case (op)
            SH_LEFT:      shifted = acc << k;
            SH_RIGHT_LOG: shifted = acc >> k;
            SH_RIGHT_ARI: shifted = $unsigned($signed(acc) >>> k);
            default:      shifted = acc;
        endcase
    end

endmodule

// File: rtl/ex_iter_unit.sv
// Execute-side unit: single-cycle logic/LUI, multi-cycle iterative shifts with
// back-pressure, registered write-back triple.
module ex_iter_unit
    import ex_iter_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [7:0]            i_exop,
    input  logic [4:0]            i_dest,
    input  logic [WORD_WIDTH-1:0] i_srcLeft,
    input  logic [WORD_WIDTH-1:0] i_srcRight,
    output logic                  o_wbValid,
    output logic [4:0]            o_wbDest,
    output logic [WORD_WIDTH-1:0] o_wbData
);

    localparam logic [5:0] STEP_W = 6'(SHIFT_STEP);
    localparam logic [4:0] STEP_K = 5'(SHIFT_STEP);

    exi_state_t            state_r, state_s;
    logic [4:0]            cnt_r, cnt_s;
    logic [WORD_WIDTH-1:0] acc_r, acc_s;
    shift_op_t             sh_op_r, sh_op_s;
    logic [4:0]            dest_r, dest_s;
    logic                  ready_r, ready_s;
    logic                  wb_valid_r, wb_valid_s;
    logic [4:0]            wb_dest_r, wb_dest_s;
    logic [WORD_WIDTH-1:0] wb_data_r, wb_data_s;
    logic [4:0]            k_s;
    logic [WORD_WIDTH-1:0] shifted_s;
    logic [2:0]            cls_s;
    logic [4:0]            op_s;

    assign cls_s = i_exop[7:5];
    assign op_s  = i_exop[4:0];

    // Per-cycle step size: the full step unless fewer bits remain.
    always_comb begin
        if ({1'b0, cnt_r} < STEP_W) begin
            k_s = cnt_r;
        end else begin
            k_s = STEP_K;
        end
    end

    ex_shift_step #(.WORD_WIDTH(WORD_WIDTH)) u_step (
        .acc     (acc_r),
        .k       (k_s),
        .op      (sh_op_r),
        .shifted (shifted_s)
    );

    // Next-state, datapath and write-back decisions; flush overrides everything.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        acc_s      = acc_r;
        sh_op_s    = sh_op_r;
        dest_s     = dest_r;
        wb_valid_s = DISABLE;
        wb_dest_s  = wb_dest_r;
        wb_data_s  = wb_data_r;
        if (i_flush) begin
            state_s = EXI_IDLE;
            cnt_s   = 5'd0;
        end else begin
            case (state_r)
                EXI_IDLE: begin
                    if (i_valid && (cls_s == EX_HIGH_LOGIC)) begin
                        case (op_s)
                            EX_LOGIC_AND, EX_LOGIC_OR, EX_LOGIC_XOR,
                            EX_LOGIC_NOR, EX_LOGIC_LUI: begin
                                case (op_s)
                                    EX_LOGIC_AND: wb_data_s = i_srcLeft & i_srcRight;
                                    EX_LOGIC_OR:  wb_data_s = i_srcLeft | i_srcRight;
                                    EX_LOGIC_XOR: wb_data_s = i_srcLeft ^ i_srcRight;
                                    EX_LOGIC_NOR: wb_data_s = ~(i_srcLeft | i_srcRight);
                                    default:      wb_data_s = {i_srcRight[15:0], {(WORD_WIDTH-16){1'b0}}};
                                endcase
                                wb_dest_s  = i_dest;
                                wb_valid_s = (i_dest != REG_ZERO);
                            end
                            EX_LOGIC_SHLEFT, EX_LOGIC_SHRIGHTLOG, EX_LOGIC_SHRIGHTARI: begin
                                if (i_srcLeft[4:0] == 5'd0) begin
                                    wb_data_s  = i_srcRight;
                                    wb_dest_s  = i_dest;
                                    wb_valid_s = (i_dest != REG_ZERO);
                                end else begin
                                    acc_s   = i_srcRight;
                                    cnt_s   = i_srcLeft[4:0];
                                    sh_op_s = to_shift_op(op_s);
                                    dest_s  = i_dest;
                                    state_s = EXI_SHIFT;
                                end
                            end
                            default: begin
                                state_s = EXI_IDLE;
                            end
                        endcase
                    end else begin
                        state_s = EXI_IDLE;
                    end
                end
                EXI_SHIFT: begin
                    acc_s = shifted_s;
                    cnt_s = cnt_r - k_s;
                    if (cnt_r == k_s) begin
                        wb_data_s  = shifted_s;
                        wb_dest_s  = dest_r;
                        wb_valid_s = (dest_r != REG_ZERO);
                        state_s    = EXI_IDLE;
                    end else begin
                        state_s = EXI_SHIFT;
                    end
                end
                default: begin
                    state_s = EXI_IDLE;
                    cnt_s   = 5'd0;
                end
            endcase
        end
        ready_s = (state_s == EXI_IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= EXI_IDLE;
            cnt_r      <= 5'd0;
            acc_r      <= ZERO_WORD;
            sh_op_r    <= SH_NONE;
            dest_r     <= REG_ZERO;
            ready_r    <= ENABLE;
            wb_valid_r <= DISABLE;
            wb_dest_r  <= REG_ZERO;
            wb_data_r  <= ZERO_WORD;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            acc_r      <= acc_s;
            sh_op_r    <= sh_op_s;
            dest_r     <= dest_s;
            ready_r    <= ready_s;
            wb_valid_r <= wb_valid_s;
            wb_dest_r  <= wb_dest_s;
            wb_data_r  <= wb_data_s;
        end
    end

    assign o_ready   = ready_r;
    assign o_wbValid = wb_valid_r;
    assign o_wbDest  = wb_dest_r;
    assign o_wbData  = wb_data_r;

endmodule

// File: tb/tb_ex_iter_unit.sv
// Scoreboard bench: two units (step 1 and step 4) share data inputs; drivers
// queue expected write-backs, per-unit monitors pop and compare.
module tb_ex_iter_unit;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_t;

    localparam logic [7:0] OP_AND  = 8'h20;
    localparam logic [7:0] OP_OR   = 8'h21;
    localparam logic [7:0] OP_XOR  = 8'h22;
    localparam logic [7:0] OP_NOR  = 8'h23;
    localparam logic [7:0] OP_SLL  = 8'h24;
    localparam logic [7:0] OP_SRL  = 8'h25;
    localparam logic [7:0] OP_SRA  = 8'h26;
    localparam logic [7:0] OP_LUI  = 8'h27;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_UNDF = 8'hE3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid1 = 1'b0, valid4 = 1'b0;
    logic [7:0]  exop = 8'h00;
    logic [4:0]  dest = 5'd0;
    logic [31:0] src_l = 32'h0, src_r = 32'h0;
    logic        ready1, ready4, wbv1, wbv4;
    logic [4:0]  wbdest1, wbdest4;
    logic [31:0] wbd1, wbd4;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_wb1 = 0, prev_wb1 = 0;
    wb_t q1[$];
    wb_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_iter_unit #(.WORD_WIDTH(32), .SHIFT_STEP(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid1),
        .o_ready(ready1), .i_exop(exop), .i_dest(dest), .i_srcLeft(src_l),
        .i_srcRight(src_r), .o_wbValid(wbv1), .o_wbDest(wbdest1), .o_wbData(wbd1)
    );

    ex_iter_unit #(.WORD_WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid4),
        .o_ready(ready4), .i_exop(exop), .i_dest(dest), .i_srcLeft(src_l),
        .i_srcRight(src_r), .o_wbValid(wbv4), .o_wbDest(wbdest4), .o_wbData(wbd4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input int d, input logic [4:0] dst, input logic [31:0] data);
        wb_t e;
        e.dest = dst;
        e.data = data;
        if (d == 1) q1.push_back(e);
        else q4.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input int d, input logic [7:0] op, input logic [4:0] dst,
                        input logic [31:0] l, input logic [31:0] r);
        int guard;
        guard = 0;
        exop = op; dest = dst; src_l = l; src_r = r;
        if (d == 1) valid1 = 1'b1;
        else valid4 = 1'b1;
        while (((d == 1) ? ready1 : ready4) !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 32'(guard), 32'd0);
        @(negedge clk);
        valid1 = 1'b0;
        valid4 = 1'b0;
    endtask

    task automatic busy_len(input int d, input int exp_cycles, input string name);
        int busy;
        busy = 0;
        while (((d == 1) ? ready1 : ready4) !== 1'b1 && busy < 60) begin
            busy++;
            @(negedge clk);
        end
        check(name, 32'(busy), 32'(exp_cycles));
    endtask

    // Monitor for the step-1 unit.
    always @(negedge clk) begin
        if (rst_n && wbv1 === 1'b1) begin
            prev_wb1 = last_wb1;
            last_wb1 = cyc;
            if (q1.size() == 0) begin
                check("u1_unexpected_wb_dest", 32'(wbdest1), 32'h0);
                check("u1_unexpected_wb_data", wbd1, 32'hxxxx_xxxx);
            end else begin
                wb_t e;
                e = q1.pop_front();
                check("u1_wb_dest", 32'(wbdest1), 32'(e.dest));
                check("u1_wb_data", wbd1, e.data);
            end
        end
    end

    // Monitor for the step-4 unit.
    always @(negedge clk) begin
        if (rst_n && wbv4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("u4_unexpected_wb_dest", 32'(wbdest4), 32'h0);
                check("u4_unexpected_wb_data", wbd4, 32'hxxxx_xxxx);
            end else begin
                wb_t e;
                e = q4.pop_front();
                check("u4_wb_dest", 32'(wbdest4), 32'(e.dest));
                check("u4_wb_data", wbd4, e.data);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_wbvalid1", 32'(wbv1), 32'd0);
        check("rst_wbdata1", wbd1, 32'h0);
        check("rst_wbdest1", 32'(wbdest1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready4", 32'(ready4), 32'd1);

        // Logic ops, back-to-back
        expect_wb(1, 5'd3, 32'h0000_FFFF);
        send(1, OP_OR, 5'd3, 32'h0000_F0F0, 32'h0000_0F0F);
        expect_wb(1, 5'd5, 32'h00F0_1200);
        send(1, OP_AND, 5'd5, 32'hF0F0_1234, 32'h0FF0_FF00);
        expect_wb(1, 5'd6, 32'h5555_5555);
        send(1, OP_XOR, 5'd6, 32'hAAAA_5555, 32'hFFFF_0000);
        @(negedge clk);
        check("b2b_consecutive", 32'(last_wb1 - prev_wb1), 32'd1);
        check("hold_wbvalid", 32'(wbv1), 32'd0);
        check("hold_wbdata", wbd1, 32'h5555_5555);
        expect_wb(1, 5'd7, 32'h0000_FFFF);
        send(1, OP_NOR, 5'd7, 32'h0000_0000, 32'hFFFF_0000);

        // Iterative shifts, step 1
        expect_wb(1, 5'd4, 32'hFC00_0000);
        send(1, OP_SRA, 5'd4, 32'd5, 32'h8000_0000);
        busy_len(1, 5, "sra5_busy");
        expect_wb(1, 5'd8, 32'h0F00_0000);
        send(1, OP_SRL, 5'd8, 32'hFFFF_FFE4, 32'hF000_0000);
        busy_len(1, 4, "srl4_busy");

        // Iterative shifts, step 4
        expect_wb(4, 5'd2, 32'h0000_0020);
        send(4, OP_SLL, 5'd2, 32'h0000_0025, 32'h0000_0001);
        busy_len(4, 2, "sll5_step4_busy");
        expect_wb(4, 5'd2, 32'hDEAD_BEEF);
        send(4, OP_SLL, 5'd2, 32'h0000_0020, 32'hDEAD_BEEF);
        check("sll0_no_busy", 32'(ready4), 32'd1);
        expect_wb(4, 5'd17, 32'hFF00_0000);
        send(4, OP_SRA, 5'd17, 32'd7, 32'h8000_0000);
        busy_len(4, 2, "sra7_step4_busy");

        // LUI to r0, LUI to r9, NOP, undefined op
        @(negedge clk);
        send(1, OP_LUI, 5'd0, 32'h0, 32'h0000_1234);
        check("lui_r0_wbvalid", 32'(wbv1), 32'd0);
        check("lui_r0_wbdata", wbd1, 32'h1234_0000);
        expect_wb(1, 5'd9, 32'h1234_0000);
        send(1, OP_LUI, 5'd9, 32'h0, 32'h0000_1234);
        send(1, OP_NOP, 5'd10, 32'h1, 32'h2);
        send(1, OP_UNDF, 5'd11, 32'h1, 32'h2);

        // Flush on the 2nd busy cycle of a 6-step SRL, with a bundle offered
        send(1, OP_SRL, 5'd12, 32'd6, 32'hFFFF_FFFF);
        @(negedge clk);
        flush = 1'b1;
        exop = OP_AND; dest = 5'd13; src_l = 32'hFFFF_FFFF; src_r = 32'hFFFF_FFFF;
        valid1 = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        valid1 = 1'b0;
        check("flush_ready", 32'(ready1), 32'd1);
        check("flush_wbvalid", 32'(wbv1), 32'd0);
        repeat (8) @(negedge clk);
        expect_wb(1, 5'd14, 32'h0000_00FF);
        send(1, OP_OR, 5'd14, 32'h0000_00F0, 32'h0000_000F);

        // Reset while shifting with 7 bits left
        @(negedge clk);
        send(1, OP_SRL, 5'd15, 32'd9, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(ready1), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready1), 32'd1);
        check("midrst_wbvalid", 32'(wbv1), 32'd0);
        check("midrst_wbdata", wbd1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_ready", 32'(ready1), 32'd1);
        expect_wb(1, 5'd16, 32'h0000_0008);
        send(1, OP_SLL, 5'd16, 32'd3, 32'h0000_0001);
        busy_len(1, 3, "post_rst_sll3_busy");

        repeat (4) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
